// File: rtl/in_channel_writer.sv
// in_channel_writer: NIn-deep input channel ring buffer with valid/ready write side and one-cycle-latency pop side.
// Ports:
//   clock        - rising-edge clock
//   reset        - synchronous active-low reset
//   in_valid     - producer offers in_data
//   in_data      - offered word
//   in_ready     - channel has room (from registered state only)
//   clear        - discard all buffered words
//   rd           - pop one word ("in" instruction)
//   rd_data      - popped word, valid the cycle after rd, held otherwise
//   rd_valid     - rd_data/rd_underflow valid this cycle
//   rd_underflow - the pop found the channel empty (rd_data is 0)
//   in_size      - number of buffered words
module in_channel_writer #(
    parameter int MemoryElementWidth = 12,
    parameter int NIn = 8
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          in_valid,
    input  logic [MemoryElementWidth-1:0] in_data,
    output logic                          in_ready,
    input  logic                          clear,
    input  logic                          rd,
    output logic [MemoryElementWidth-1:0] rd_data,
    output logic                          rd_valid,
    output logic                          rd_underflow,
    output logic [7:0]                    in_size
);
    localparam int PW = NIn > 1 ? $clog2(NIn) : 1;
    localparam logic [PW-1:0] LAST = PW'(NIn - 1);
    localparam logic [7:0] DEPTH = 8'(NIn);

    logic [MemoryElementWidth-1:0] mem_q [NIn];
    logic [PW-1:0]                 wp_q, wp_d, rp_q, rp_d;
    logic [7:0]                    size_q, size_d;
    logic [MemoryElementWidth-1:0] rd_data_q, rd_data_d;
    logic                          rd_valid_q, rd_valid_d;
    logic                          rd_uf_q, rd_uf_d;
    logic                          acc, pop, uf;

    assign in_ready     = size_q < DEPTH;
    assign in_size      = size_q;
    assign rd_data      = rd_data_q;
    assign rd_valid     = rd_valid_q;
    assign rd_underflow = rd_uf_q;

    always_comb begin
        acc        = in_valid && in_ready && !clear;
        pop        = rd && !clear && size_q != 8'd0;
        // a pop coinciding with clear sees the channel already emptied
        uf         = rd && !pop;
        wp_d       = clear ? '0 : acc ? (wp_q == LAST ? '0 : wp_q + PW'(1)) : wp_q;
        rp_d       = clear ? '0 : pop ? (rp_q == LAST ? '0 : rp_q + PW'(1)) : rp_q;
        size_d     = clear ? 8'd0 :
                     (acc && !pop) ? size_q + 8'd1 :
                     (pop && !acc) ? size_q - 8'd1 : size_q;
        rd_data_d  = pop ? mem_q[rp_q] : uf ? '0 : rd_data_q;
        rd_valid_d = rd;
        rd_uf_d    = uf;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            wp_q       <= '0;
            rp_q       <= '0;
            size_q     <= 8'd0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            rd_uf_q    <= 1'b0;
        end else begin
            wp_q       <= wp_d;
            rp_q       <= rp_d;
            size_q     <= size_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            rd_uf_q    <= rd_uf_d;
        end
    end

    // ring contents need no reset: nothing is readable while in_size is 0
    always_ff @(posedge clock) begin
        if (reset && acc) mem_q[wp_q] <= in_data;
    end
endmodule

// File: tb/tb_in_channel_writer.sv
// tb_in_channel_writer: queue-model checking of in_channel_writer plus directed literal checks.
module tb_in_channel_writer;
    localparam int W = 12;
    localparam int N = 8;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         in_valid = 1'b0;
    logic [W-1:0] in_data = '0;
    logic         in_ready;
    logic         clear = 1'b0;
    logic         rd = 1'b0;
    logic [W-1:0] rd_data;
    logic         rd_valid;
    logic         rd_underflow;
    logic [7:0]   in_size;

    int errors = 0;
    int checks = 0;
    bit started = 1'b0;

    in_channel_writer #(.MemoryElementWidth(W), .NIn(N)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .clear(clear), .rd(rd), .rd_data(rd_data),
        .rd_valid(rd_valid), .rd_underflow(rd_underflow), .in_size(in_size)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a plain FIFO queue; the popped word, or 0 on underflow, appears one cycle later.
    logic [W-1:0] q[$];
    logic [W-1:0] m_data = '0;
    bit           m_valid = 1'b0;
    bit           m_uf = 1'b0;

    always @(posedge clock) begin
        bit room;
        started = 1'b1;
        if (!reset) begin
            q.delete();
            m_data = '0;
            m_valid = 1'b0;
            m_uf = 1'b0;
        end else if (clear) begin
            q.delete();
            m_valid = rd;
            m_uf = rd;
            if (rd) m_data = '0;
        end else begin
            room = q.size() < N;
            m_valid = rd;
            m_uf = 1'b0;
            if (rd) begin
                if (q.size() > 0) m_data = q.pop_front();
                else begin
                    m_data = '0;
                    m_uf = 1'b1;
                end
            end
            if (in_valid && room) q.push_back(in_data);
        end
    end

    always @(negedge clock) begin
        if (started) begin
            chk("model in_ready", int'(in_ready), int'(q.size() < N));
            chk("model in_size", int'(in_size), q.size());
            chk("model rd_valid", int'(rd_valid), int'(m_valid));
            chk("model rd_underflow", int'(rd_underflow), int'(m_uf));
            chk("model rd_data", int'(rd_data), int'(m_data));
        end
    end

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic push(input int v);
        in_valid = 1'b1;
        in_data = W'(v);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic pop_chk(input string name, input int v, input int u);
        rd = 1'b1;
        tick();
        rd = 1'b0;
        chk({name, " rd_valid"}, int'(rd_valid), 1);
        chk({name, " rd_data"}, int'(rd_data), v);
        chk({name, " rd_underflow"}, int'(rd_underflow), u);
    endtask

    initial begin
        tick();
        tick();
        reset = 1'b1;
        chk("reset in_ready", int'(in_ready), 1);
        chk("reset in_size", int'(in_size), 0);
        chk("reset rd_valid", int'(rd_valid), 0);
        chk("reset rd_data", int'(rd_data), 0);

        push(1); push(2); push(3);
        chk("three in_size", int'(in_size), 3);
        pop_chk("pop1", 1, 0);
        pop_chk("pop2", 2, 0);
        pop_chk("pop3", 3, 0);
        chk("three drained", int'(in_size), 0);
        tick();
        chk("idle rd_valid", int'(rd_valid), 0);
        chk("idle rd_data held", int'(rd_data), 3);

        pop_chk("empty", 0, 1);
        chk("empty in_size", int'(in_size), 0);

        for (int i = 0; i < 8; i++) push(10 + i);
        chk("full in_ready", int'(in_ready), 0);
        chk("full in_size", int'(in_size), 8);
        in_valid = 1'b1;
        in_data = W'(99);
        tick();
        chk("held in_size", int'(in_size), 8);
        rd = 1'b1;
        tick();
        rd = 1'b0;
        chk("full pop data", int'(rd_data), 10);
        chk("full pop in_size", int'(in_size), 7);
        chk("full pop in_ready", int'(in_ready), 1);
        tick();
        in_valid = 1'b0;
        chk("ninth accepted", int'(in_size), 8);
        for (int i = 1; i < 8; i++) pop_chk("full drain", 10 + i, 0);
        pop_chk("ninth word", 99, 0);

        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1;
            in_data = W'(100 + i);
            rd = i >= 2;
            tick();
        end
        in_valid = 1'b0;
        rd = 1'b0;
        chk("interleave in_size", int'(in_size), 2);
        pop_chk("interleave a", 118, 0);
        pop_chk("interleave b", 119, 0);

        for (int i = 0; i < 5; i++) push(40 + i);
        clear = 1'b1;
        in_valid = 1'b1;
        in_data = W'(77);
        tick();
        clear = 1'b0;
        in_valid = 1'b0;
        chk("clear in_size", int'(in_size), 0);
        pop_chk("after clear", 0, 1);

        push(5); push(6); push(7);
        rd = 1'b1;
        tick();
        rd = 1'b0;
        reset = 1'b0;
        tick();
        chk("reset pop rd_valid", int'(rd_valid), 0);
        chk("reset pop in_size", int'(in_size), 0);
        chk("reset pop in_ready", int'(in_ready), 1);
        reset = 1'b1;
        tick();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/in_channel_writer.md
IN_CHANNEL_WRITER -- requirements
Module: in_channel_writer

Interface
REQ-001 SHALL have parameter MemoryElementWidth, default 12, meaning the width of each channel word.
REQ-002 SHALL have parameter NIn, default 8, meaning the input channel depth in words; legal range 1..255.
REQ-003 SHALL have port clock  input  1  meaning the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  meaning the reset, synchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  meaning the external producer offers in_data.
REQ-006 SHALL have port in_data  input  MemoryElementWidth  meaning the offered word.
REQ-007 SHALL have port in_ready  output  1  meaning the channel can accept a word this cycle.
REQ-008 SHALL have port clear  input  1  meaning discard all buffered words.
REQ-009 SHALL have port rd  input  1  meaning the program executes an "in" instruction and pops one word.
REQ-010 SHALL have port rd_data  output  MemoryElementWidth  meaning the popped word.
REQ-011 SHALL have port rd_valid  output  1  meaning rd_data and rd_underflow are valid this cycle.
REQ-012 SHALL have port rd_underflow  output  1  meaning the pop found the channel empty.
REQ-013 SHALL have port in_size  output  8  meaning the number of buffered words, as returned by an "inSize" instruction.

Function
REQ-014 SHALL store words in an NIn-entry ring with write position inMemPos-style wp and read position rp, both wrapping NIn-1 -> 0.
REQ-015 SHALL drive in_ready = (in_size < NIn) combinationally from registered state only, never from rd in the same cycle.
REQ-016 SHALL accept a word on a rising edge where in_valid && in_ready && !clear: store at wp, advance wp, increment in_size.
REQ-017 SHALL ignore in_valid while in_ready is low; producer holds in_data/in_valid until accepted.
REQ-018 SHALL, on a rising edge with rd && !clear and in_size > 0, register the word at rp to rd_data, advance rp, decrement in_size, and assert rd_valid with rd_underflow=0 for exactly the next cycle (latency 1).
REQ-019 SHALL, on rd with in_size == 0, assert rd_valid and rd_underflow for one cycle with rd_data = 0, leaving pointers and in_size unchanged; a word accepted the same edge is not bypassed.
REQ-020 SHALL, on simultaneous accept and non-empty pop, perform both; in_size unchanged.
REQ-021 SHALL, when full, refuse the write even if rd pops on the same edge; in_ready rises the following cycle.
REQ-022 SHALL, on clear, set wp=rp=0 and in_size=0, drop any same-edge write, and treat a same-edge rd as underflow.
REQ-023 SHALL keep rd_valid and rd_underflow low in every cycle not following an rd.
REQ-024 SHALL hold rd_data at its last value when rd_valid is low.
REQ-025 SHALL keep in_size within 0..NIn at all times.

Reset
REQ-026 SHALL, when reset is low at a rising edge, set wp=rp=0, in_size=0, rd_valid=0, rd_underflow=0, rd_data=0, and in_ready=1 after that edge.
REQ-027 SHALL give reset priority over clear, rd and in_valid; a pop in flight when reset asserts produces no rd_valid.
REQ-028 SHALL leave ring contents undefined after reset; they are never observable because in_size=0.

Verification
REQ-029 SHALL cover: write 1, 2, 3 then three rd pulses -> rd_data 1, 2, 3, each one cycle after rd, rd_underflow=0, in_size ends 0.
REQ-030 SHALL cover: NIn=8, write 8 words -> in_ready=0, in_size=8; 9th word held; rd + in_valid same edge -> pop only, in_ready=1 next cycle, 9th word accepted on the edge after.
REQ-031 SHALL cover: rd on empty -> rd_valid=1, rd_underflow=1, rd_data=0, in_size stays 0.
REQ-032 SHALL cover: write 20 words interleaved with pops (never full) -> output order matches input, pointers wrap twice.
REQ-033 SHALL cover: 5 words buffered, clear with in_valid=1 -> in_size=0, word dropped, next rd underflows.
REQ-034 SHALL cover: 3 words buffered, rd then reset low next edge -> no rd_valid, in_size=0, in_ready=1.
